dmem_arbiter: RTL and testbench

//  Two-port arbiter sharing the single data memory between the pipeline load/store path (port 0) and a

---
 rtl/dmem_arbiter.sv | 149 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: port 0 fixed priority with a starvation guard for port 1.
// Define DMEM_ARB_RR_EN to replace the starvation guard with round-robin on contended cycles.
`ifndef RV32_ADDR_WIDTH
`define RV32_ADDR_WIDTH 32
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif
`ifndef DMEM_DATA_WIDTH
`define DMEM_DATA_WIDTH 32
`endif

module dmem_arbiter #(
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned CNT_W        = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [1:0]                  i_req_valid,
   output logic [1:0]                  o_req_ready,
   input  logic [`RV32_ADDR_WIDTH-1:0] i_req_addr0,
   input  logic [`RV32_ADDR_WIDTH-1:0] i_req_addr1,
   input  logic [1:0]                  i_req_wr_en,
   input  logic [`RV32_DATA_WIDTH-1:0] i_req_wr_data0,
   input  logic [`RV32_DATA_WIDTH-1:0] i_req_wr_data1,
   output logic [1:0]                  o_rsp_valid,
   output logic [`DMEM_DATA_WIDTH-1:0] o_rsp_data,
   output logic                        o_rsp_err,
   output logic [`RV32_ADDR_WIDTH-1:0] o_mem_addr,
   output logic                        o_mem_wr_en,
   output logic [`RV32_DATA_WIDTH-1:0] o_mem_wr_data,
   input  logic [`DMEM_DATA_WIDTH-1:0] i_mem_rd_data
);

   localparam int unsigned AW = `RV32_ADDR_WIDTH;

   logic [1:0]                  gnt;
   logic                        prefer1;
   logic                        accept;
   logic                        sel1;
   logic [AW-1:0]               sel_addr;
   logic [`RV32_DATA_WIDTH-1:0] sel_wdata;
   logic                        sel_we;
   logic                        aligned;
   logic [AW-1:0]               word_idx;

   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic          rsp_pend_q, rsp_pend_d;
   logic          rsp_owner_q, rsp_owner_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_rd_q, rsp_rd_d;

`ifdef DMEM_ARB_RR_EN
   logic rr_ptr_q, rr_ptr_d;

   assign prefer1 = rr_ptr_q;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (i_req_valid == 2'b11 && accept)
         rr_ptr_d = ~rr_ptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rr_ptr_q <= 1'b0;
      else        rr_ptr_q <= rr_ptr_d;
   end
`else
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

   assign prefer1 = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

   always_comb begin
      starve_cnt_d = '0;
      if (i_req_valid[1] && !gnt[1]) begin
         if (starve_cnt_q != CNT_W'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + 1'b1;
         else
            starve_cnt_d = starve_cnt_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_cnt_q <= '0;
      else        starve_cnt_q <= starve_cnt_d;
   end
`endif

   // Grants are held off while reset is asserted so no access leaks into dmem.
   always_comb begin
      gnt = '0;
      if (rst_n) begin
         case (i_req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prefer1 ? 2'b10 : 2'b01;
            default: gnt = '0;
         endcase
      end
   end

   assign o_req_ready = gnt;
   assign accept      = |gnt;
   assign sel1        = gnt[1];
   assign sel_addr    = sel1 ? i_req_addr1    : i_req_addr0;
   assign sel_wdata   = sel1 ? i_req_wr_data1 : i_req_wr_data0;
   assign sel_we      = sel1 ? i_req_wr_en[1] : i_req_wr_en[0];
   assign aligned     = (sel_addr[1:0] == 2'b00);
   assign word_idx    = {2'b00, sel_addr[AW-1:2]};

   assign o_mem_addr    = accept ? word_idx : mem_addr_q;
   assign o_mem_wr_en   = accept & sel_we & aligned;
   assign o_mem_wr_data = sel_wdata;

   always_comb begin
      mem_addr_d  = mem_addr_q;
      rsp_pend_d  = accept;
      rsp_owner_d = rsp_owner_q;
      rsp_err_d   = 1'b0;
      rsp_rd_d    = 1'b0;
      if (accept) begin
         mem_addr_d  = word_idx;
         rsp_owner_d = sel1;
         rsp_err_d   = ~aligned;
         rsp_rd_d    = ~sel_we & aligned;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_addr_q  <= '0;
         rsp_pend_q  <= 1'b0;
         rsp_owner_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rd_q    <= 1'b0;
      end else begin
         mem_addr_q  <= mem_addr_d;
         rsp_pend_q  <= rsp_pend_d;
         rsp_owner_q <= rsp_owner_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rd_q    <= rsp_rd_d;
      end
   end

   assign o_rsp_valid = rsp_pend_q ? (rsp_owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign o_rsp_err   = rsp_pend_q & rsp_err_q;
   assign o_rsp_data  = (rsp_pend_q && rsp_rd_q) ? i_mem_rd_data : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench for dmem_arbiter against a transaction-level model of grant order and memory contents.
module tb_dmem_arbiter;

   localparam int STARVE_LIMIT = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  i_req_valid;
   logic [1:0]  o_req_ready;
   logic [31:0] i_req_addr0, i_req_addr1;
   logic [1:0]  i_req_wr_en;
   logic [31:0] i_req_wr_data0, i_req_wr_data1;
   logic [1:0]  o_rsp_valid;
   logic [31:0] o_rsp_data;
   logic        o_rsp_err;
   logic [31:0] o_mem_addr;
   logic        o_mem_wr_en;
   logic [31:0] o_mem_wr_data;
   logic [31:0] i_mem_rd_data;

   dmem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr0(i_req_addr0), .i_req_addr1(i_req_addr1),
      .i_req_wr_en(i_req_wr_en),
      .i_req_wr_data0(i_req_wr_data0), .i_req_wr_data1(i_req_wr_data1),
      .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
      .o_mem_addr(o_mem_addr), .o_mem_wr_en(o_mem_wr_en), .o_mem_wr_data(o_mem_wr_data),
      .i_mem_rd_data(i_mem_rd_data)
   );

   always #5 clk = ~clk;

   // Environment: synchronous-read data memory, 64 words.
   logic [31:0] dmem [64];
   logic [31:0] rd_q;
   always @(posedge clk) begin
      rd_q <= dmem[o_mem_addr[5:0]];
      if (o_mem_wr_en) dmem[o_mem_addr[5:0]] <= o_mem_wr_data;
   end
   assign i_mem_rd_data = rd_q;

   // Reference model state.
   logic [31:0] ref_mem [64];
   int          refused;
   bit          rr_pref;
   bit          exp_pend, exp_owner, exp_err;
   logic [31:0] exp_data;
   int          p1_grants;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      refused  = 0;
      rr_pref  = 1'b0;
      exp_pend = 1'b0;
   endtask

   function automatic logic [31:0] gen_addr();
      logic [31:0] a;
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom);
      return a;
   endfunction

   task automatic cycle(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [1:0] we, input logic [31:0] d0, input logic [31:0] d1);
      bit          g0, g1, contended, wr, al;
      logic [31:0] a, d;
      @(negedge clk);
      rst_n          = 1'b1;
      i_req_valid    = v;
      i_req_addr0    = a0;
      i_req_addr1    = a1;
      i_req_wr_en    = we;
      i_req_wr_data0 = d0;
      i_req_wr_data1 = d1;
      #1;
      chk("rsp_valid", {30'd0, o_rsp_valid}, exp_pend ? (exp_owner ? 32'd2 : 32'd1) : 32'd0);
      if (exp_pend) begin
         chk("rsp_data", o_rsp_data, exp_data);
         chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, exp_err});
      end
      contended = (v == 2'b11);
`ifdef DMEM_ARB_RR_EN
      g1 = (v == 2'b10) || (contended && rr_pref);
      if (contended) rr_pref = ~rr_pref;
`else
      g1 = (v == 2'b10) || (contended && refused >= STARVE_LIMIT);
      if (v[1] && !g1) refused = (refused < STARVE_LIMIT) ? refused + 1 : refused;
      else             refused = 0;
`endif
      g0 = v[0] && !g1;
      if (g1) p1_grants++;
      chk("req_ready", {30'd0, o_req_ready}, {30'd0, g1, g0});
      if (g0 || g1) begin
         a  = g1 ? a1 : a0;
         d  = g1 ? d1 : d0;
         wr = g1 ? we[1] : we[0];
         al = (a[1:0] == 2'b00);
         chk("mem_addr", o_mem_addr, a >> 2);
         chk("mem_wr_en", {31'd0, o_mem_wr_en}, {31'd0, wr && al});
         if (wr && al) chk("mem_wr_data", o_mem_wr_data, d);
         exp_pend  = 1'b1;
         exp_owner = g1;
         exp_err   = !al;
         exp_data  = (wr || !al) ? 32'd0 : ref_mem[a[7:2]];
         if (wr && al) ref_mem[a[7:2]] = d;
      end else begin
         chk("mem_wr_en_idle", {31'd0, o_mem_wr_en}, 32'd0);
         exp_pend = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         dmem[i]    = $urandom;
         ref_mem[i] = dmem[i];
      end
      model_reset();
      p1_grants      = 0;
      rst_n          = 1'b0;
      i_req_valid    = 2'b11;
      i_req_addr0    = 32'h10;
      i_req_addr1    = 32'h20;
      i_req_wr_en    = 2'b11;
      i_req_wr_data0 = 32'h1111_1111;
      i_req_wr_data1 = 32'h2222_2222;
      #12;
      chk("rst_rsp_valid", {30'd0, o_rsp_valid}, 32'd0);
      chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
      chk("rst_mem_wr_en", {31'd0, o_mem_wr_en}, 32'd0);
      chk("rst_ready", {30'd0, o_req_ready}, 32'd0);

      // Port 0 read of 0x10 (word 4); reset released with both requests pending.
      cycle(2'b01, 32'h10, 32'h0, 2'b00, 32'h0, 32'h0);
      // Port 1 write then read of 0x8.
      cycle(2'b10, 32'h0, 32'h8, 2'b10, 32'h0, 32'hDEAD_BEEF);
      cycle(2'b10, 32'h0, 32'h8, 2'b00, 32'h0, 32'h0);
      // Misaligned port 0 write.
      cycle(2'b01, 32'h6, 32'h0, 2'b01, 32'hCAFE_F00D, 32'h0);
      cycle(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);
      chk("rd_back_0x8", ref_mem[2], 32'hDEAD_BEEF);

      // Continuous contention.
      p1_grants = 0;
      for (int i = 0; i < 27; i++)
         cycle(2'b11, gen_addr(), gen_addr(), 2'($urandom), $urandom, $urandom);
`ifdef DMEM_ARB_RR_EN
      chk("contended_p1_grants", p1_grants, 32'd13);
`else
      chk("contended_p1_grants", p1_grants, 32'd3);
`endif

      // Reset asserted in the cycle after an accept drops the response.
      cycle(2'b01, 32'h24, 32'h0, 2'b00, 32'h0, 32'h0);
      @(negedge clk);
      rst_n       = 1'b0;
      i_req_valid = 2'b11;
      i_req_wr_en = 2'b11;
      #1;
      model_reset();
      chk("rstdrop_rsp_valid", {30'd0, o_rsp_valid}, 32'd0);
      chk("rstdrop_mem_wr_en", {31'd0, o_mem_wr_en}, 32'd0);
      @(negedge clk);
      #1;
      chk("rstdrop_rsp_valid2", {30'd0, o_rsp_valid}, 32'd0);
      cycle(2'b11, 32'h30, 32'h34, 2'b00, 32'h0, 32'h0);
      cycle(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);

      for (int i = 0; i < 400; i++)
         cycle(2'($urandom), gen_addr(), gen_addr(), 2'($urandom), $urandom, $urandom);
      cycle(2'b00, 32'h0, 32'h0, 2'b00, 32'h0, 32'h0);

      for (int i = 0; i < 64; i++)
         chk("final_mem", dmem[i], ref_mem[i]);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
